// File: rtl/avalon_burst_if.sv
// avalon_burst_if: split write/read Avalon-MM burst channel bundle
interface avalon_burst_if #(
    parameter int AW = 17,
    parameter int DW = 16
);
    logic [AW-1:0] wr_address;
    logic          wr_write;
    logic [DW-1:0] wr_writedata;
    logic [5:0]    wr_burstcount;
    logic          wr_waitrequest;
    logic [AW-1:0] rd_address;
    logic          rd_read;
    logic [5:0]    rd_burstcount;
    logic          rd_waitrequest;
    logic          rd_readdatavalid;
    logic [DW-1:0] rd_readdata;
    modport master (
        output wr_address, wr_write, wr_writedata, wr_burstcount,
        output rd_address, rd_read, rd_burstcount,
        input  wr_waitrequest, rd_waitrequest, rd_readdatavalid, rd_readdata
    );
    modport slave (
        input  wr_address, wr_write, wr_writedata, wr_burstcount,
        input  rd_address, rd_read, rd_burstcount,
        output wr_waitrequest, rd_waitrequest, rd_readdatavalid, rd_readdata
    );
endinterface

// File: rtl/avalon_burst_responder.sv
// avalon_burst_responder: Avalon-MM burst slave serving split write/read channels from one single-port RAM
module avalon_burst_responder #(
    parameter int AW         = 17,
    parameter int DW         = 16,
    parameter int MW         = 10,
    parameter int STARVE_LIM = 8
) (
    input logic          clk,
    input logic          reset,
    avalon_burst_if.slave bus
);
    localparam int CW = $clog2(STARVE_LIM + 1);
    typedef enum logic {W_IDLE, W_BURST} w_state_t;
    typedef enum logic {R_IDLE, R_BUSY} r_state_t;
    w_state_t      w_state_q, w_state_d;
    r_state_t      r_state_q, r_state_d;
    logic [MW-1:0] w_addr_q, w_addr_d, r_addr_q, r_addr_d, w_cur_addr, mem_addr;
    logic [5:0]    w_rem_q, w_rem_d, r_rem_q, r_rem_d, wr_n, rd_n;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          wr_wait_q, wr_wait_d, rd_wait_q, rd_wait_d;
    logic          pipe_v_q, pipe_v_d, rdv_q, rdv_d;
    logic [DW-1:0] rdata_q, rdata_d, ram_dout;
    logic [DW-1:0] mem [2**MW];
    logic          wr_acc, rd_acc, rd_issue, unused_addr_hi;
    assign wr_acc         = bus.wr_write && !wr_wait_q;
    assign rd_acc         = bus.rd_read && !rd_wait_q;
    assign rd_issue       = (r_state_q == R_BUSY) && !wr_acc;
    assign wr_n           = (bus.wr_burstcount == 6'd0) ? 6'd1 : bus.wr_burstcount;
    assign rd_n           = (bus.rd_burstcount == 6'd0) ? 6'd1 : bus.rd_burstcount;
    assign w_cur_addr     = (w_state_q == W_IDLE) ? bus.wr_address[MW-1:0] : w_addr_q;
    assign mem_addr       = wr_acc ? w_cur_addr : r_addr_q;
    assign unused_addr_hi = ^{bus.wr_address[AW-1:MW], bus.rd_address[AW-1:MW]};
    assign bus.wr_waitrequest   = wr_wait_q;
    assign bus.rd_waitrequest   = rd_wait_q;
    assign bus.rd_readdatavalid = rdv_q;
    assign bus.rd_readdata      = rdata_q;

    // Write FSM: first beat latches base/count, later beats walk the burst
    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_rem_d   = w_rem_q;
        if (wr_acc) begin
            w_addr_d  = w_cur_addr + MW'(1);
            w_rem_d   = (w_state_q == W_IDLE) ? wr_n - 6'd1 : w_rem_q - 6'd1;
            w_state_d = (w_rem_d == 6'd0) ? W_IDLE : W_BURST;
        end
    end

    // Read FSM: one command latches the burst, beats issue whenever the port is free
    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_rem_d   = r_rem_q;
        if (rd_acc) begin
            r_state_d = R_BUSY;
            r_addr_d  = bus.rd_address[MW-1:0];
            r_rem_d   = rd_n;
        end else if (rd_issue) begin
            r_addr_d  = r_addr_q + MW'(1);
            r_rem_d   = r_rem_q - 6'd1;
            r_state_d = (r_rem_q == 6'd1) ? R_IDLE : R_BUSY;
        end
    end

    // Starvation guard and registered outputs; a stall slot lets one read beat through
    always_comb begin
        wcnt_d    = (wr_acc && r_state_q == R_BUSY) ? wcnt_q + CW'(1) : '0;
        wr_wait_d = (wcnt_d == CW'(STARVE_LIM));
        if (wr_wait_d) wcnt_d = '0;
        rd_wait_d = (r_state_d == R_BUSY);
        pipe_v_d  = rd_issue;
        rdv_d     = pipe_v_q;
        rdata_d   = pipe_v_q ? ram_dout : rdata_q;
    end

    // State registers; reset flushes both FSMs and the read pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            w_addr_q  <= '0;
            r_addr_q  <= '0;
            w_rem_q   <= '0;
            r_rem_q   <= '0;
            wcnt_q    <= '0;
            wr_wait_q <= 1'b1;
            rd_wait_q <= 1'b1;
            pipe_v_q  <= 1'b0;
            rdv_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            w_addr_q  <= w_addr_d;
            r_addr_q  <= r_addr_d;
            w_rem_q   <= w_rem_d;
            r_rem_q   <= r_rem_d;
            wcnt_q    <= wcnt_d;
            wr_wait_q <= wr_wait_d;
            rd_wait_q <= rd_wait_d;
            pipe_v_q  <= pipe_v_d;
            rdv_q     <= rdv_d;
            rdata_q   <= rdata_d;
        end
    end

    // Single-port RAM: an accepted write owns the port, otherwise a pending read beat uses it
    always_ff @(posedge clk) begin
        if (wr_acc && !reset) mem[mem_addr] <= bus.wr_writedata;
        else if (rd_issue) ram_dout <= mem[mem_addr];
    end
endmodule

// File: tb/tb_avalon_burst_responder.sv
// tb_avalon_burst_responder: scoreboard bench for the burst responder
module tb_avalon_burst_responder;
    localparam int AW = 17;
    localparam int DW = 16;
    localparam int MW = 10;
    logic clk = 0;
    logic reset = 1;
    always #5 clk = ~clk;
    avalon_burst_if #(.AW(AW), .DW(DW)) bus ();
    avalon_burst_responder #(.AW(AW), .DW(DW), .MW(MW), .STARVE_LIM(8)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    logic [15:0] model [int];
    logic [15:0] exp_q [$];
    int compared = 0;
    int mismatched = 0;
    int stall_cnt = 0;
    int acc_since = 0;
    logic prev_stall = 0;
    bit mon_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every read beat and watches write stall slots
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rd_readdatavalid) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_rdv: got data %h with nothing outstanding", bus.rd_readdata);
                end else check("rd_data", bus.rd_readdata, exp_q.pop_front());
            end
            if (mon_en) begin
                if (bus.wr_write && !bus.wr_waitrequest) acc_since++;
                if (bus.wr_waitrequest) begin
                    stall_cnt++;
                    check("beats_before_stall", acc_since, 8);
                    check("stall_single_cycle", prev_stall, 0);
                    acc_since = 0;
                end
                prev_stall = bus.wr_waitrequest;
            end
        end
    end

    task automatic write_burst(input int addr, input int bc, input int d0, input int gap_at = -1, input int gap_len = 0);
        int beats;
        int t;
        bit acc;
        beats = (bc == 0) ? 1 : bc;
        for (int i = 0; i < beats; i++) begin
            bus.wr_write      = 1;
            bus.wr_address    = (i == 0) ? AW'(addr) : AW'(addr ^ 'h155);
            bus.wr_burstcount = (i == 0) ? 6'(bc) : 6'(bc ^ 5);
            bus.wr_writedata  = 16'(d0 + i);
            t = 0;
            acc = 0;
            while (!acc && t < 100) begin
                @(negedge clk);
                acc = !bus.wr_waitrequest;
                tick();
                t++;
            end
            if (!acc) begin
                compared++;
                mismatched++;
                $display("FAIL wr_accept_timeout: beat %0d not accepted", i);
            end
            model[(addr + i) % 1024] = 16'(d0 + i);
            bus.wr_write = 0;
            if (i == gap_at) repeat (gap_len) begin
                @(negedge clk);
                check("wr_wait_in_gap", bus.wr_waitrequest, 0);
                tick();
            end
        end
    endtask

    task automatic read_cmd(input int addr, input int bc);
        int beats;
        int t;
        bit acc;
        beats = (bc == 0) ? 1 : bc;
        bus.rd_read       = 1;
        bus.rd_address    = AW'(addr);
        bus.rd_burstcount = 6'(bc);
        t = 0;
        acc = 0;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = !bus.rd_waitrequest;
            tick();
            t++;
        end
        if (!acc) begin
            compared++;
            mismatched++;
            $display("FAIL rd_accept_timeout: command at %h not accepted", addr);
        end
        bus.rd_read = 0;
        for (int i = 0; i < beats; i++) exp_q.push_back(model[(addr + i) % 1024]);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            tick();
            t++;
        end
        check("drain_outstanding", exp_q.size(), 0);
        repeat (5) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.wr_address = '0; bus.wr_write = 0; bus.wr_writedata = '0; bus.wr_burstcount = '0;
        bus.rd_address = '0; bus.rd_read = 0; bus.rd_burstcount = '0;
        tick();
        check("rst_wr_wait", bus.wr_waitrequest, 1);
        check("rst_rd_wait", bus.rd_waitrequest, 1);
        check("rst_rdv", bus.rd_readdatavalid, 0);
        check("rst_rdata", bus.rd_readdata, 0);
        repeat (2) tick();
        reset = 0;
        tick();
        check("post_rst_wr_wait", bus.wr_waitrequest, 0);
        check("post_rst_rd_wait", bus.rd_waitrequest, 0);
        // single write then single read with exact latency
        write_burst('h005, 1, 'hA5A5);
        read_cmd('h005, 1);
        check("t1_rd_wait_T1", bus.rd_waitrequest, 1);
        check("t1_rdv_T1", bus.rd_readdatavalid, 0);
        tick();
        check("t1_rd_wait_T2", bus.rd_waitrequest, 0);
        check("t1_rdv_T2", bus.rd_readdatavalid, 0);
        tick();
        check("t1_rdv_T3", bus.rd_readdatavalid, 1);
        tick();
        check("t1_rdv_T4", bus.rd_readdatavalid, 0);
        drain();
        // wrapping burst
        write_burst('h3FC, 8, 1);
        read_cmd('h3FC, 8);
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            check("t2_rdv_back_to_back", bus.rd_readdatavalid, 1);
            tick();
        end
        check("t2_rdv_after_burst", bus.rd_readdatavalid, 0);
        drain();
        read_cmd('h000, 4);
        drain();
        // stalled write burst, neighbour word must stay untouched
        write_burst('h014, 1, 'hBEEF);
        write_burst('h010, 4, 'h0100, 1, 3);
        read_cmd('h010, 5);
        drain();
        // starvation limit under a long write burst
        write_burst('h100, 16, 'h1000);
        read_cmd('h100, 16);
        mon_en = 1;
        write_burst('h200, 32, 'h2000);
        repeat (3) tick();
        mon_en = 0;
        check("t4_stall_count", stall_cnt, 4);
        drain();
        read_cmd('h200, 32);
        drain();
        // reset mid write burst with a read outstanding
        read_cmd('h100, 4);
        tick();
        bus.wr_write = 1; bus.wr_address = AW'('h040); bus.wr_burstcount = 6'd8; bus.wr_writedata = 16'h0401;
        tick();
        bus.wr_writedata = 16'h0402;
        tick();
        bus.wr_writedata = 16'h0403;
        reset = 1;
        exp_q.delete();
        tick();
        check("t5_rst_wr_wait", bus.wr_waitrequest, 1);
        check("t5_rst_rd_wait", bus.rd_waitrequest, 1);
        check("t5_rst_rdv", bus.rd_readdatavalid, 0);
        reset = 0;
        bus.wr_write = 0;
        model['h040] = 16'h0401;
        model['h041] = 16'h0402;
        tick();
        check("t5_post_wr_wait", bus.wr_waitrequest, 0);
        check("t5_post_rd_wait", bus.rd_waitrequest, 0);
        repeat (4) tick();
        write_burst('h080, 4, 'h0800);
        read_cmd('h040, 2);
        read_cmd('h080, 4);
        drain();
        // zero burstcount on both channels, upper address bits ignored
        write_burst('h300, 0, 'h3333);
        write_burst('h310, 1, 'h4444);
        read_cmd('h10300, 0);
        read_cmd('h310, 0);
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
